fir_secuenciador: RTL and testbench

Time-multiplexed FIR controller that shares one signed N×N multiplier and one saturating 2N→N truncation stage across TAPS coefficient products per input sample. It holds the sample delay line, addresses an external coefficient store, accumulates with saturation and emits one N-bit result per accepted sample. It sits between the sample source and the filter output in the fixed-point datapath.

---
 rtl/fir_secuenciador_pkg.sv | 17 +
 rtl/fir_secuenciador_sat_suma.sv | 23 ++
 rtl/fir_secuenciador.sv | 132 +++++++++++++
 tb/tb_fir_secuenciador.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_secuenciador_pkg.sv
// Shared constants for the time-multiplexed FIR controller: data format,
// FSM state encoding and the N-bit signed saturation limits.
package fir_secuenciador_pkg;

  localparam int N = 16;  // sample / coefficient / result width
  localparam int F = 8;   // fractional bits, Q(N-F).F

  localparam logic signed [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/fir_secuenciador_sat_suma.sv
// N-bit signed saturating adder with overflow flag (accumulator stage).
module sat_suma
  import fir_secuenciador_pkg::*;
(
  input  logic signed [N-1:0] i_a,
  input  logic signed [N-1:0] i_b,
  output logic signed [N-1:0] o_suma,
  output logic                o_desborde
);

  logic signed [N:0] w_ext;

  assign w_ext = $signed({i_a[N-1], i_a}) + $signed({i_b[N-1], i_b});

  // Overflow shows up as the two top bits of the N+1 bit sum disagreeing;
  // the top bit then tells which rail to clamp to.
  always_comb begin
    o_desborde = (w_ext[N] != w_ext[N-1]);
    o_suma     = w_ext[N-1:0];
    if (o_desborde) o_suma = w_ext[N] ? MIN_N : MAX_N;
  end

endmodule

// File: rtl/fir_secuenciador.sv
// Time-multiplexed FIR controller: one shared signed multiplier plus a
// saturating truncation stage, one tap per cycle, one result per sample.
// Optional macro FIR_REDONDEO_EN: round-half-up before the shift instead
// of truncating toward -inf.
module fir_secuenciador
  import fir_secuenciador_pkg::*;
#(
  parameter  int TAPS = 8,
  localparam int AW   = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] muestra_in,
  input  logic                muestra_valida,
  output logic                listo,
  output logic [AW-1:0]       coef_addr,
  input  logic signed [N-1:0] coef_dato,
  output logic signed [N-1:0] resultado,
  output logic                resultado_valido,
  output logic                saturo
);

  estado_t             r_estado, w_sig;
  logic signed [N-1:0] r_x [TAPS];
  logic signed [N-1:0] r_acc;
  logic [AW-1:0]       r_k;
  logic                r_sat;
  logic signed [N-1:0] r_resultado;
  logic                r_valido;
  logic                r_saturo;

  logic signed [2*N-1:0] w_prod;
  logic signed [2*N:0]   w_prod_r;
  logic signed [2*N:0]   w_q_ancho;
  logic signed [N-1:0]   w_q;
  logic                  w_sat_q;
  logic                  w_cabe;
  logic signed [N-1:0]   w_suma;
  logic                  w_desb;
  logic                  w_ultimo;

  assign listo            = (r_estado == IDLE);
  assign coef_addr        = (r_estado == MAC) ? r_k : '0;
  assign resultado        = r_resultado;
  assign resultado_valido = r_valido;
  assign saturo           = r_saturo;
  assign w_ultimo         = (r_k == AW'(TAPS - 1));

  // Full-precision product; operands sign-extended so the 2N-bit result is exact.
  assign w_prod = $signed({{N{r_x[r_k][N-1]}}, r_x[r_k]})
                * $signed({{N{coef_dato[N-1]}}, coef_dato});

`ifdef FIR_REDONDEO_EN
  localparam logic signed [2*N:0] W_RND = (2*N+1)'(1) << (F - 1);
  assign w_prod_r = $signed({w_prod[2*N-1], w_prod}) + W_RND;
`else
  assign w_prod_r = $signed({w_prod[2*N-1], w_prod});
`endif

  assign w_q_ancho = w_prod_r >>> F;

  // Clamp the shifted product to N bits: it fits only if every bit above
  // the N-bit sign position is a copy of it.
  always_comb begin
    w_cabe  = (&w_q_ancho[2*N:N-1]) | ~(|w_q_ancho[2*N:N-1]);
    w_sat_q = ~w_cabe;
    w_q     = w_q_ancho[N-1:0];
    if (!w_cabe) w_q = w_q_ancho[2*N] ? MIN_N : MAX_N;
  end

  sat_suma u_acc (
    .i_a        (r_acc),
    .i_b        (w_q),
    .o_suma     (w_suma),
    .o_desborde (w_desb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= IDLE;
    else        r_estado <= w_sig;
  end

  // Next state: accept in IDLE, TAPS MAC cycles, one DONE cycle.
  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      IDLE:    if (muestra_valida) w_sig = MAC;
      MAC:     if (w_ultimo)       w_sig = DONE;
      DONE:    w_sig = IDLE;
      default: w_sig = IDLE;
    endcase
  end

  // Delay line, accumulator, tap index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_sat       <= 1'b0;
      r_resultado <= '0;
      r_valido    <= 1'b0;
      r_saturo    <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      case (r_estado)
        IDLE: begin
          if (muestra_valida) begin
            for (int i = TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
            r_x[0] <= muestra_in;
            r_acc  <= '0;
            r_sat  <= 1'b0;
            r_k    <= '0;
          end
        end
        MAC: begin
          r_acc <= w_suma;
          r_sat <= r_sat | w_sat_q | w_desb;
          r_k   <= w_ultimo ? '0 : r_k + 1'b1;
        end
        DONE: begin
          r_resultado <= r_acc;
          r_saturo    <= r_sat;
          r_valido    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_secuenciador.sv
// Self-checking bench for fir_secuenciador: directed cases plus randomized
// samples against an arithmetic reference model of the filter.
module tb_fir_secuenciador;
  import fir_secuenciador_pkg::*;

  localparam int TAPS = 8;
  localparam int AW   = $clog2(TAPS);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [N-1:0] muestra_in = '0;
  logic                muestra_valida = 1'b0;
  logic                listo;
  logic [AW-1:0]       coef_addr;
  logic signed [N-1:0] coef_dato;
  logic signed [N-1:0] resultado;
  logic                resultado_valido;
  logic                saturo;

  logic signed [N-1:0] coef [TAPS];
  longint              dl [TAPS];
  int n_chk = 0, n_pass = 0;

  assign coef_dato = coef[coef_addr];

  always #5 clk = ~clk;

  fir_secuenciador #(.TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .muestra_in(muestra_in),
    .muestra_valida(muestra_valida), .listo(listo), .coef_addr(coef_addr),
    .coef_dato(coef_dato), .resultado(resultado),
    .resultado_valido(resultado_valido), .saturo(saturo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clampn(input longint v, inout logic s);
    longint mx, mn;
    mx = (longint'(1) << (N - 1)) - 1;
    mn = -(longint'(1) << (N - 1));
    if (v > mx) begin s = 1'b1; return mx; end
    if (v < mn) begin s = 1'b1; return mn; end
    return v;
  endfunction

  // Reference: sum of tap products, each scaled by 2^-F and clamped, with a
  // clamped running sum.
  task automatic modelo(output logic [N-1:0] r, output logic s);
    longint acc, p, q;
    acc = 0; s = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      p = dl[k] * longint'(coef[k]);
`ifdef FIR_REDONDEO_EN
      p = p + (longint'(1) << (F - 1));
`endif
      q   = clampn(fdiv(p, longint'(1) << F), s);
      acc = clampn(acc + q, s);
    end
    r = acc[N-1:0];
  endtask

  task automatic limpiar_modelo();
    for (int i = 0; i < TAPS; i++) dl[i] = 0;
  endtask

  task automatic hacer_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    limpiar_modelo();
  endtask

  // Feed one sample; optionally strobe an extra sample at E0+2 that must be
  // dropped. Checks addressing, busy, latency and the result.
  task automatic muestra(input logic [N-1:0] x, input bit busy,
                         output logic [N-1:0] res, output logic sat);
    logic [N-1:0] er;
    logic         es;
    int           w;
    w = 0;
    @(negedge clk);
    while (!listo && w < 40) begin @(negedge clk); w++; end
    chk("listo_wait", {31'd0, listo}, 32'd1);
    muestra_in = x; muestra_valida = 1'b1;
    @(posedge clk);  // E0
    for (int i = TAPS - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = longint'($signed(x));
    modelo(er, es);
    for (int i = 1; i <= TAPS + 1; i++) begin
      @(negedge clk);
      muestra_valida = busy && (i == 2);
      if (i == 2) muestra_in = N'($urandom);
      chk("valido_pronto", {31'd0, resultado_valido}, 32'd0);
      chk("listo_ocupado", {31'd0, listo}, 32'd0);
      chk("coef_addr", {29'd0, coef_addr}, (i <= TAPS) ? 32'(i - 1) : 32'd0);
    end
    @(negedge clk);
    chk("valido_pulso", {31'd0, resultado_valido}, 32'd1);
    chk("resultado", {16'd0, resultado}, {16'd0, er});
    chk("saturo", {31'd0, saturo}, {31'd0, es});
    res = resultado; sat = saturo;
    @(negedge clk);
    chk("valido_un_ciclo", {31'd0, resultado_valido}, 32'd0);
    chk("listo_vuelve", {31'd0, listo}, 32'd1);
    chk("resultado_mantiene", {16'd0, resultado}, {16'd0, er});
  endtask

  initial begin
    logic [N-1:0] r;
    logic         s;
    bit           vio;
    limpiar_modelo();
    for (int k = 0; k < TAPS; k++) coef[k] = '0;

    // Reset state
    #12;
    chk("rst_listo", {31'd0, listo}, 32'd1);
    chk("rst_addr", {29'd0, coef_addr}, 32'd0);
    chk("rst_res", {16'd0, resultado}, 32'd0);
    chk("rst_valido", {31'd0, resultado_valido}, 32'd0);
    chk("rst_saturo", {31'd0, saturo}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Impulse through an increasing-coefficient filter
    for (int k = 0; k < TAPS; k++) coef[k] = N'(16'h0100 * (k + 1));
    for (int j = 0; j < TAPS; j++) begin
      muestra((j == 0) ? 16'h0100 : 16'h0000, 1'b0, r, s);
      chk("impulso_res", {16'd0, r}, 32'(16'h0100 * (j + 1)));
      chk("impulso_sat", {31'd0, s}, 32'd0);
    end

    // Positive saturation, then recovery once the line is all zero
    for (int k = 0; k < TAPS; k++) coef[k] = 16'h7FFF;
    hacer_reset();
    muestra(16'h7FFF, 1'b0, r, s);
    chk("satpos_res", {16'd0, r}, 32'h7FFF);
    chk("satpos_sat", {31'd0, s}, 32'd1);
    for (int j = 0; j < TAPS; j++) muestra(16'h0000, 1'b0, r, s);
    chk("cero_res", {16'd0, r}, 32'h0000);
    chk("cero_sat", {31'd0, s}, 32'd0);

    // Negative saturation with a full line
    for (int j = 0; j < TAPS; j++) muestra(16'h8000, 1'b0, r, s);
    chk("satneg_res", {16'd0, r}, 32'h8000);
    chk("satneg_sat", {31'd0, s}, 32'd1);

    // Rounding vs truncation
    hacer_reset();
    for (int k = 0; k < TAPS; k++) coef[k] = '0;
    coef[0] = 16'h0080;
    muestra(16'h0001, 1'b0, r, s);
`ifdef FIR_REDONDEO_EN
    chk("redondeo", {16'd0, r}, 32'h0001);
`else
    chk("redondeo", {16'd0, r}, 32'h0000);
`endif

    // Reset during tap 3
    for (int k = 0; k < TAPS; k++) coef[k] = 16'h0100;
    @(negedge clk);
    muestra_in = 16'h1234; muestra_valida = 1'b1;
    @(negedge clk); muestra_valida = 1'b0;
    repeat (3) @(negedge clk);
    chk("mac_addr3", {29'd0, coef_addr}, 32'd3);
    rst_n = 1'b0; #1;
    chk("rmac_listo", {31'd0, listo}, 32'd1);
    chk("rmac_addr", {29'd0, coef_addr}, 32'd0);
    chk("rmac_res", {16'd0, resultado}, 32'd0);
    chk("rmac_valido", {31'd0, resultado_valido}, 32'd0);
    chk("rmac_saturo", {31'd0, saturo}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    limpiar_modelo();
    vio = 1'b0;
    @(negedge clk);
    chk("rmac_listo_post", {31'd0, listo}, 32'd1);
    for (int i = 0; i < TAPS + 4; i++) begin
      @(negedge clk);
      if (resultado_valido) vio = 1'b1;
    end
    chk("rmac_sin_valido", {31'd0, vio}, 32'd0);

    // Randomized samples and coefficients, some with a dropped busy strobe
    for (int j = 0; j < 24; j++) begin
      if (j % 8 == 0) begin
        for (int k = 0; k < TAPS; k++)
          coef[k] = (j < 16) ? N'(int'($urandom_range(1024, 0)) - 512) : N'($urandom);
      end
      if (j < 16) muestra(N'(int'($urandom_range(8192, 0)) - 4096), ($urandom_range(1, 0) == 1), r, s);
      else        muestra(N'($urandom), ($urandom_range(1, 0) == 1), r, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
